// File: rtl/rf_access_ctrl_pkg.sv
// Shared op codes and FSM state encoding for rf_access_ctrl.
// S_INIT exists only when RF_ACC_INIT_EN is defined.
package rf_access_ctrl_pkg;

    localparam logic [1:0] RF_OP_WR   = 2'd0;
    localparam logic [1:0] RF_OP_RD   = 2'd1;
    localparam logic [1:0] RF_OP_CPY  = 2'd2;
    localparam logic [1:0] RF_OP_RSVD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_WRITE  = 3'd3,
        S_RSP    = 3'd4
`ifdef RF_ACC_INIT_EN
        ,
        S_INIT   = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/rf_access_ctrl.sv
// Serialises WR/RD/CPY commands onto a 1W/2R regfile and returns RD results on a response channel.
// RF_ACC_INIT_EN: after reset, sweep zeros into every regfile entry before accepting commands.
module rf_access_ctrl
    import rf_access_ctrl_pkg::*;
#(
    parameter int BW_DATA = 16,
    parameter int BW_ADDR = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [1:0]         i_cmd_op,
    input  logic [BW_ADDR-1:0] i_cmd_addr_a,
    input  logic [BW_ADDR-1:0] i_cmd_addr_b,
    input  logic [BW_DATA-1:0] i_cmd_data,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [BW_DATA-1:0] o_rsp_data0,
    output logic [BW_DATA-1:0] o_rsp_data1,
    output logic               o_rf_wr_en,
    output logic [BW_ADDR-1:0] o_rf_wr_addr,
    output logic [BW_DATA-1:0] o_rf_wr_data,
    output logic [BW_ADDR-1:0] o_rf_rd_addr0,
    output logic [BW_ADDR-1:0] o_rf_rd_addr1,
    input  logic [BW_DATA-1:0] i_rf_rd_data0,
    input  logic [BW_DATA-1:0] i_rf_rd_data1
);

    state_t             state_reg, state_next;
    logic [1:0]         op_reg, op_next;
    logic [BW_ADDR-1:0] addr_a_reg, addr_a_next;
    logic [BW_ADDR-1:0] addr_b_reg, addr_b_next;
    logic [BW_DATA-1:0] data_reg, data_next;
    logic [BW_DATA-1:0] cap0_reg, cap0_next;
    logic [BW_DATA-1:0] cap1_reg, cap1_next;
    logic               rsp_valid_reg, rsp_valid_next;
    logic               wr_en_reg, wr_en_next;
    logic [BW_ADDR-1:0] wr_addr_reg, wr_addr_next;
    logic [BW_DATA-1:0] wr_data_reg, wr_data_next;
    logic [BW_ADDR-1:0] rd_addr0_reg, rd_addr0_next;
    logic [BW_ADDR-1:0] rd_addr1_reg, rd_addr1_next;
`ifdef RF_ACC_INIT_EN
    logic [BW_ADDR-1:0] init_cnt_reg, init_cnt_next;
`endif

    assign o_cmd_ready   = (state_reg == S_IDLE);
    assign o_rsp_valid   = rsp_valid_reg;
    assign o_rsp_data0   = cap0_reg;
    assign o_rsp_data1   = cap1_reg;
    assign o_rf_wr_en    = wr_en_reg;
    assign o_rf_wr_addr  = wr_addr_reg;
    assign o_rf_wr_data  = wr_data_reg;
    assign o_rf_rd_addr0 = rd_addr0_reg;
    assign o_rf_rd_addr1 = rd_addr1_reg;

    // Regfile port registers are loaded with the value for the state being entered,
    // so each port is driven exactly while the FSM sits in READ or WRITE.
    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        addr_a_next    = addr_a_reg;
        addr_b_next    = addr_b_reg;
        data_next      = data_reg;
        cap0_next      = cap0_reg;
        cap1_next      = cap1_reg;
        rsp_valid_next = rsp_valid_reg;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        rd_addr0_next  = rd_addr0_reg;
        rd_addr1_next  = rd_addr1_reg;
`ifdef RF_ACC_INIT_EN
        init_cnt_next  = init_cnt_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    op_next     = i_cmd_op;
                    addr_a_next = i_cmd_addr_a;
                    addr_b_next = i_cmd_addr_b;
                    data_next   = i_cmd_data;
                    state_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op_reg)
                    RF_OP_WR: begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = addr_a_reg;
                        wr_data_next = data_reg;
                        state_next   = S_WRITE;
                    end
                    RF_OP_RD: begin
                        rd_addr0_next = addr_a_reg;
                        rd_addr1_next = addr_b_reg;
                        state_next    = S_READ;
                    end
                    RF_OP_CPY: begin
                        rd_addr0_next = addr_a_reg;
                        rd_addr1_next = addr_a_reg;
                        state_next    = S_READ;
                    end
                    default: state_next = S_IDLE;
                endcase
            end
            S_READ: begin
                cap0_next = i_rf_rd_data0;
                cap1_next = i_rf_rd_data1;
                if (op_reg == RF_OP_RD) begin
                    rsp_valid_next = 1'b1;
                    state_next     = S_RSP;
                end else begin
                    // copy source is taken straight from the read port as it is captured
                    wr_en_next   = 1'b1;
                    wr_addr_next = addr_b_reg;
                    wr_data_next = i_rf_rd_data0;
                    state_next   = S_WRITE;
                end
            end
            S_WRITE: begin
                state_next = S_IDLE;
            end
            S_RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end
`ifdef RF_ACC_INIT_EN
            S_INIT: begin
                // counter runs one ahead of the address on the port; zero means 2**BW_ADDR-1 was issued
                if (init_cnt_reg == '0) begin
                    state_next = S_IDLE;
                end else begin
                    wr_en_next    = 1'b1;
                    wr_addr_next  = init_cnt_reg;
                    wr_data_next  = '0;
                    init_cnt_next = init_cnt_reg + 1'b1;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_reg        <= RF_OP_WR;
            addr_a_reg    <= '0;
            addr_b_reg    <= '0;
            data_reg      <= '0;
            cap0_reg      <= '0;
            cap1_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            rd_addr0_reg  <= '0;
            rd_addr1_reg  <= '0;
`ifdef RF_ACC_INIT_EN
            // the sweep's first write (address 0) is on the port in the first cycle after reset
            state_reg     <= S_INIT;
            wr_en_reg     <= 1'b1;
            init_cnt_reg  <= BW_ADDR'(1);
`else
            state_reg     <= S_IDLE;
            wr_en_reg     <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            addr_a_reg    <= addr_a_next;
            addr_b_reg    <= addr_b_next;
            data_reg      <= data_next;
            cap0_reg      <= cap0_next;
            cap1_reg      <= cap1_next;
            rsp_valid_reg <= rsp_valid_next;
            wr_en_reg     <= wr_en_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            rd_addr0_reg  <= rd_addr0_next;
            rd_addr1_reg  <= rd_addr1_next;
`ifdef RF_ACC_INIT_EN
            init_cnt_reg  <= init_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Self-checking bench for rf_access_ctrl with a behavioural regfile and an array-based reference model.
// Define RF_ACC_INIT_EN for both bench and RTL to exercise the zero sweep after reset.
module tb_rf_access_ctrl;

    localparam int BW_DATA = 16;
    localparam int BW_ADDR = 4;
    localparam int N_REG   = 16;
    localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_CPY = 2'd2, OP_RSVD = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [BW_ADDR-1:0] cmd_addr_a;
    logic [BW_ADDR-1:0] cmd_addr_b;
    logic [BW_DATA-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [BW_DATA-1:0] rsp_data0;
    logic [BW_DATA-1:0] rsp_data1;
    logic               rf_wr_en;
    logic [BW_ADDR-1:0] rf_wr_addr;
    logic [BW_DATA-1:0] rf_wr_data;
    logic [BW_ADDR-1:0] rf_rd_addr0;
    logic [BW_ADDR-1:0] rf_rd_addr1;
    logic [BW_DATA-1:0] rf_rd_data0;
    logic [BW_DATA-1:0] rf_rd_data1;

    logic [BW_DATA-1:0] rf_mem   [N_REG];
    logic [BW_DATA-1:0] load_val [N_REG];
    logic               load;
    logic [BW_DATA-1:0] model    [N_REG];

    int vectors     = 0;
    int miscompares = 0;
    int txn_count   = 0;

    rf_access_ctrl #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_op      (cmd_op),
        .i_cmd_addr_a  (cmd_addr_a),
        .i_cmd_addr_b  (cmd_addr_b),
        .i_cmd_data    (cmd_data),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_data0   (rsp_data0),
        .o_rsp_data1   (rsp_data1),
        .o_rf_wr_en    (rf_wr_en),
        .o_rf_wr_addr  (rf_wr_addr),
        .o_rf_wr_data  (rf_wr_data),
        .o_rf_rd_addr0 (rf_rd_addr0),
        .o_rf_rd_addr1 (rf_rd_addr1),
        .i_rf_rd_data0 (rf_rd_data0),
        .i_rf_rd_data1 (rf_rd_data1)
    );

    // behavioural regfile: synchronous write, combinational reads
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N_REG; i++) rf_mem[i] <= load_val[i];
        end else if (rf_wr_en) begin
            rf_mem[rf_wr_addr] <= rf_wr_data;
        end
    end
    assign rf_rd_data0 = rf_mem[rf_rd_addr0];
    assign rf_rd_data1 = rf_mem[rf_rd_addr1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one command and return just after its accept edge
    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [15:0] d);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_addr_a = a;
        cmd_addr_b = b;
        cmd_data   = d;
        step();
        cmd_valid  = 1'b0;
        cmd_op     = 2'($urandom);
        cmd_addr_a = 4'($urandom);
        cmd_addr_b = 4'($urandom);
        cmd_data   = 16'($urandom);
    endtask

    // sample index k = just after the k-th posedge following the accept edge
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [15:0] d, input int stall);
        int nwr = 0, wr_idx = -1, ready_low = 0, rsp_idx = -1, idx = 0;
        bit done = 0;
        logic [3:0]  wa = '0;
        logic [15:0] wd = '0;
        logic [15:0] e0, e1;
        logic [3:0]  rd0_before, rd1_before;
        e0 = model[a];
        e1 = model[b];
        rd0_before = rf_rd_addr0;
        rd1_before = rf_rd_addr1;
        txn_count++;
        $display("txn %0d: op=%0d a=%0d b=%0d d=%04h stall=%0d", txn_count, op, a, b, d, stall);
        issue(op, a, b, d);
        while (!done && idx < 40) begin
            if (rf_wr_en === 1'b1) begin
                nwr++;
                wr_idx = idx;
                wa = rf_wr_addr;
                wd = rf_wr_data;
            end
            if (rsp_valid === 1'b1 && rsp_idx < 0) begin
                rsp_idx = idx;
                check("rsp_data", {rsp_data0, rsp_data1}, {e0, e1});
                for (int s = 0; s < stall; s++) begin
                    step();
                    idx++;
                    check("rsp_hold", {rsp_valid, cmd_ready, rsp_data0, rsp_data1},
                          {1'b1, 1'b0, e0, e1});
                end
                rsp_ready = 1'b1;
                step();
                idx++;
                rsp_ready = 1'b0;
                check("rsp_release", rsp_valid, 1'b0);
            end
            if (cmd_ready === 1'b1) begin
                done = 1;
            end else begin
                ready_low++;
                step();
                idx++;
            end
        end
        check("cmd_timeout", done, 1'b1);
        case (op)
            OP_WR: begin
                check("wr_count", nwr, 1);
                check("wr_latency", wr_idx, 1);
                check("wr_port", {wa, wd}, {a, d});
                check("wr_ready_low", ready_low, 2);
                model[a] = d;
            end
            OP_CPY: begin
                check("cpy_count", nwr, 1);
                check("cpy_latency", wr_idx, 2);
                check("cpy_port", {wa, wd}, {b, e0});
                check("cpy_ready_low", ready_low, 3);
                check("cpy_rd_addr", {rf_rd_addr0, rf_rd_addr1}, {a, a});
                model[b] = e0;
            end
            OP_RD: begin
                check("rd_no_write", nwr, 0);
                check("rd_rd_addr", {rf_rd_addr0, rf_rd_addr1}, {a, b});
            end
            default: begin
                check("rsvd_no_write", nwr, 0);
                check("rsvd_ready_low", ready_low, 1);
                check("rsvd_rd_addr", {rf_rd_addr0, rf_rd_addr1}, {rd0_before, rd1_before});
            end
        endcase
        check("rsp_latency", rsp_idx, (op == OP_RD) ? 2 : -1);
    endtask

    initial begin
        int writes;
        int k;
        rst        = 1'b1;
        load       = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_addr_a = '0;
        cmd_addr_b = '0;
        cmd_data   = '0;
        rsp_ready  = 1'b0;
        for (int i = 0; i < N_REG; i++) begin
`ifdef RF_ACC_INIT_EN
            load_val[i] = 16'hFFFF;
`else
            load_val[i] = 16'($urandom);
`endif
            model[i] = load_val[i];
        end
        step();
        load = 1'b0;
        step();
        rst = 1'b0;

`ifdef RF_ACC_INIT_EN
        // zero sweep: one write per cycle, addresses in order, ready first seen in cycle 17
        writes = 0;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 40) begin
            if (rf_wr_en === 1'b1) begin
                check("init_wr", {rf_wr_addr, rf_wr_data}, {4'(writes), 16'h0000});
                writes++;
            end
            step();
            k++;
        end
        check("init_write_count", writes, 16);
        check("init_ready_cycle", k, 16);
        for (int i = 0; i < N_REG; i++) model[i] = '0;
        run_cmd(OP_RD, 4'($urandom), 4'($urandom), 16'h0, 0);
`else
        check("reset_state", {cmd_ready, rsp_valid, rf_wr_en, rf_wr_addr, rf_rd_addr0, rf_rd_addr1},
              {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0});
        writes = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rf_wr_en === 1'b1) writes++;
        end
        check("reset_no_wr", writes, 0);
`endif

        // directed: write then same-address read
        run_cmd(OP_WR, 4'd3, 4'd0, 16'hBEEF, 0);
        run_cmd(OP_RD, 4'd3, 4'd3, 16'h0, 0);

        // directed: copy then read both ends
        run_cmd(OP_WR, 4'd5, 4'd0, 16'h1234, 0);
        run_cmd(OP_WR, 4'd9, 4'd0, 16'h00FF, 0);
        run_cmd(OP_CPY, 4'd5, 4'd9, 16'h0, 0);
        run_cmd(OP_RD, 4'd5, 4'd9, 16'h0, 0);
        run_cmd(OP_CPY, 4'd9, 4'd9, 16'h0, 0);

        // back-pressure on the response channel, then a following command
        run_cmd(OP_RD, 4'd3, 4'd5, 16'h0, 5);
        run_cmd(OP_WR, 4'd1, 4'd0, 16'hA5A5, 0);

`ifndef RF_ACC_INIT_EN
        // reset while a response is pending
        issue(OP_RD, 4'd1, 4'd3, 16'h0);
        k = 0;
        while (rsp_valid !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        check("rsp_before_reset", rsp_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rsp_dropped", {rsp_valid, cmd_ready, rf_wr_en}, 3'b010);
        writes = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rf_wr_en === 1'b1) writes++;
        end
        check("rsp_reset_no_wr", writes, 0);

        // reset sampled in the WRITE cycle: that write still lands
        issue(OP_WR, 4'd12, 4'd0, 16'hC0DE);
        step();
        check("wr_before_reset", rf_wr_en, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model[12] = 16'hC0DE;
        check("wr_commit_at_reset", rf_mem[12], 16'hC0DE);
        check("wr_reset_state", {rf_wr_en, cmd_ready}, 2'b01);

        // reset before the write is issued: no write ever appears
        issue(OP_WR, 4'd13, 4'd0, 16'hDEAD);
        rst = 1'b1;
        step();
        rst = 1'b0;
        writes = 0;
        for (int i = 0; i < 4; i++) begin
            if (rf_wr_en === 1'b1) writes++;
            step();
        end
        check("aborted_wr", writes, 0);
        check("aborted_wr_mem", rf_mem[13], model[13]);
`endif

        // powers of two, then mirrored read pairs, then a reserved op
        for (int i = 0; i < N_REG; i++) run_cmd(OP_WR, 4'(i), 4'd0, 16'(1 << i), 0);
        for (int i = 0; i < N_REG; i++) run_cmd(OP_RD, 4'(i), 4'(15 - i), 16'h0, 0);
        run_cmd(OP_RSVD, 4'd6, 4'd7, 16'h5555, 0);

        // random mix
        for (int n = 0; n < 60; n++) begin
            run_cmd(2'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < N_REG; i++) check("final_mem", rf_mem[i], model[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
